// File: rtl/vid_timing_pkg.sv
// Shared 720p60 frame geometry for the display timing generator and the DDR3 read side.
// Keeping it in one place ensures the prefetch logic and the raster always agree on frame size.
package vid_timing_pkg;

   localparam int VT_CNT_W    = 12;

   localparam int VT_H_ACTIVE = 1280;
   localparam int VT_H_FP     = 110;
   localparam int VT_H_SYNC   = 40;
   localparam int VT_H_BP     = 220;

   localparam int VT_V_ACTIVE = 720;
   localparam int VT_V_FP     = 5;
   localparam int VT_V_SYNC   = 5;
   localparam int VT_V_BP     = 20;

   function automatic int vt_total(input int active, input int fp, input int sync_w, input int bp);
      return active + fp + sync_w + bp;
   endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counter pair.
// When disabled or in reset, it parks at the start of vertical front porch.
module vid_timing_cnt
   import vid_timing_pkg::*;
#(
   parameter int CNT_W   = VT_CNT_W,
   parameter int H_TOTAL = vt_total(VT_H_ACTIVE, VT_H_FP, VT_H_SYNC, VT_H_BP),
   parameter int V_TOTAL = vt_total(VT_V_ACTIVE, VT_V_FP, VT_V_SYNC, VT_V_BP),
   parameter int V_IDLE  = VT_V_ACTIVE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_PARK = CNT_W'(V_IDLE);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         h_cnt <= '0;
         v_cnt <= V_PARK;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vid_timing_gen.sv
// Programmable raster timing generator for the HDMI path: syncs, DE, FIFO read
// request, frame-start pulse for DDR3 prefetch, and a sticky FIFO underflow flag.
module vid_timing_gen
   import vid_timing_pkg::*;
#(
   parameter int H_ACTIVE = VT_H_ACTIVE,
   parameter int H_FP     = VT_H_FP,
   parameter int H_SYNC   = VT_H_SYNC,
   parameter int H_BP     = VT_H_BP,
   parameter int V_ACTIVE = VT_V_ACTIVE,
   parameter int V_FP     = VT_V_FP,
   parameter int V_SYNC   = VT_V_SYNC,
   parameter int V_BP     = VT_V_BP,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int CNT_W    = VT_CNT_W
) (
   input  logic             sclk,
   input  logic             s_rst,
   input  logic             i_gen_en,
   input  logic             i_fifo_empty,
   input  logic             i_clr_underflow,
   output logic             o_vga_hsync,
   output logic             o_vga_vsync,
   output logic             o_vga_de,
   output logic             o_fifo_rd_en,
   output logic             o_frame_start,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_underflow
);

   localparam int H_TOTAL = vt_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = vt_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;

   logic             de_p0;
   logic             hs_p0;
   logic             vs_p0;
   logic             fs_p0;

   logic             de_p1;
   logic             hs_p1;
   logic             vs_p1;
   logic             fs_p1;
   logic [CNT_W-1:0] x_p1;
   logic [CNT_W-1:0] y_p1;
   logic             underflow;

   vid_timing_cnt #(
      .CNT_W   (CNT_W),
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL),
      .V_IDLE  (V_ACTIVE)
   ) u_cnt (
      .clk   (sclk),
      .rst   (s_rst),
      .en    (i_gen_en),
      .h_cnt (h_cnt),
      .v_cnt (v_cnt)
   );

   // Stage p0: decode of the pre-increment counter state
   always_comb begin
      de_p0 = 1'b0;
      hs_p0 = 1'b0;
      vs_p0 = 1'b0;
      fs_p0 = 1'b0;
      de_p0 = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      hs_p0 = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
      vs_p0 = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
      fs_p0 = (h_cnt == '0) && (v_cnt == VS_BEG_C);
   end

   // Stage p1: registered outputs, forced inactive whenever the generator is idle
   always_ff @(posedge sclk) begin
      if (s_rst || !i_gen_en) begin
         de_p1 <= 1'b0;
         hs_p1 <= ~HS_POL;
         vs_p1 <= ~VS_POL;
         fs_p1 <= 1'b0;
         x_p1  <= '0;
         y_p1  <= '0;
      end else begin
         de_p1 <= de_p0;
         hs_p1 <= hs_p0 ? HS_POL : ~HS_POL;
         vs_p1 <= vs_p0 ? VS_POL : ~VS_POL;
         fs_p1 <= fs_p0;
         x_p1  <= de_p0 ? h_cnt : '0;
         y_p1  <= de_p0 ? v_cnt : '0;
      end
   end

   // Set has priority over clear so a coincident underflow is never lost
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         underflow <= 1'b0;
      end else if (de_p1 && i_fifo_empty) begin
         underflow <= 1'b1;
      end else if (i_clr_underflow) begin
         underflow <= 1'b0;
      end
   end

   assign o_vga_de      = de_p1;
   assign o_fifo_rd_en  = de_p1;
   assign o_vga_hsync   = hs_p1;
   assign o_vga_vsync   = vs_p1;
   assign o_frame_start = fs_p1;
   assign o_x           = x_p1;
   assign o_y           = y_p1;
   assign o_underflow   = underflow;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen on a small 16x8 raster, with positive- and
// negative-polarity instances driven from the same stimulus.
module tb_vid_timing_gen;

   localparam int CW = 12;

   logic          sclk = 1'b0;
   logic          s_rst;
   logic          gen_en;
   logic          fifo_empty;
   logic          clr_uf;

   logic          hs_a, vs_a, de_a, rd_a, fs_a, uf_a;
   logic [CW-1:0] x_a, y_a;
   logic          hs_b, vs_b, de_b, rd_b, fs_b, uf_b;
   logic [CW-1:0] x_b, y_b;

   int            checks = 0;
   int            errors = 0;
   int            cur_n  = 0;

   logic          e_de, e_hs, e_vs, e_fs;
   int            e_x, e_y;
   logic          exp_uf;
   logic          cur_de;

   always #5 sclk = ~sclk;

   vid_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
   ) dut_a (
      .sclk(sclk), .s_rst(s_rst), .i_gen_en(gen_en), .i_fifo_empty(fifo_empty),
      .i_clr_underflow(clr_uf), .o_vga_hsync(hs_a), .o_vga_vsync(vs_a),
      .o_vga_de(de_a), .o_fifo_rd_en(rd_a), .o_frame_start(fs_a),
      .o_x(x_a), .o_y(y_a), .o_underflow(uf_a)
   );

   vid_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
   ) dut_b (
      .sclk(sclk), .s_rst(s_rst), .i_gen_en(gen_en), .i_fifo_empty(fifo_empty),
      .i_clr_underflow(clr_uf), .o_vga_hsync(hs_b), .o_vga_vsync(vs_b),
      .o_vga_de(de_b), .o_fifo_rd_en(rd_b), .o_frame_start(fs_b),
      .o_x(x_b), .o_y(y_b), .o_underflow(uf_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (n=%0d): observed %0h expected %0h", tag, cur_n, obs, exp);
      end
   endtask

   // Advance one edge; the underflow expectation follows set-over-clear priority.
   task automatic step();
      logic nxt;
      if (s_rst)                    nxt = 1'b0;
      else if (cur_de && fifo_empty) nxt = 1'b1;
      else if (clr_uf)              nxt = 1'b0;
      else                          nxt = exp_uf;
      @(posedge sclk);
      #1;
      exp_uf = nxt;
   endtask

   // Edge n after enable shows the decode of raster position (64 + n - 1) mod 128.
   task automatic calc(input int n);
      int pos, h, v;
      pos  = (64 + n - 1) % 128;
      h    = pos % 16;
      v    = pos / 16;
      e_de = (h < 8) && (v < 4);
      e_hs = (h >= 10) && (h < 13);
      e_vs = (v >= 5) && (v < 7);
      e_fs = (h == 0) && (v == 5);
      e_x  = e_de ? h : 0;
      e_y  = e_de ? v : 0;
   endtask

   task automatic check_run(input int n);
      cur_n = n;
      calc(n);
      check("de_a",    32'(de_a), 32'(e_de));
      check("rd_a",    32'(rd_a), 32'(e_de));
      check("hs_a",    32'(hs_a), 32'(e_hs));
      check("vs_a",    32'(vs_a), 32'(e_vs));
      check("fs_a",    32'(fs_a), 32'(e_fs));
      check("x_a",     32'(x_a),  32'(e_x));
      check("y_a",     32'(y_a),  32'(e_y));
      check("uf_a",    32'(uf_a), 32'(exp_uf));
      check("hs_b",    32'(hs_b), 32'(!e_hs));
      check("vs_b",    32'(vs_b), 32'(!e_vs));
      check("de_b",    32'(de_b), 32'(e_de));
      check("rd_b",    32'(rd_b), 32'(e_de));
      check("fs_b",    32'(fs_b), 32'(e_fs));
      check("x_b",     32'(x_b),  32'(e_x));
      check("y_b",     32'(y_b),  32'(e_y));
      check("uf_b",    32'(uf_b), 32'(exp_uf));
      cur_de = e_de;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_de"},   32'(de_a), 32'd0);
      check({tag, "_rd"},   32'(rd_a), 32'd0);
      check({tag, "_hs"},   32'(hs_a), 32'd0);
      check({tag, "_vs"},   32'(vs_a), 32'd0);
      check({tag, "_fs"},   32'(fs_a), 32'd0);
      check({tag, "_x"},    32'(x_a),  32'd0);
      check({tag, "_y"},    32'(y_a),  32'd0);
      check({tag, "_uf"},   32'(uf_a), 32'(exp_uf));
      check({tag, "_hs_b"}, 32'(hs_b), 32'd1);
      check({tag, "_vs_b"}, 32'(vs_b), 32'd1);
      check({tag, "_de_b"}, 32'(de_b), 32'd0);
      cur_de = 1'b0;
   endtask

   initial begin
      s_rst      = 1'b1;
      gen_en     = 1'b0;
      fifo_empty = 1'b0;
      clr_uf     = 1'b0;
      exp_uf     = 1'b0;
      cur_de     = 1'b0;

      step(); step(); step();
      check_idle("reset");
      check("reset_uf_zero", 32'(uf_a), 32'd0);

      s_rst  = 1'b0;
      gen_en = 1'b1;
      for (int n = 1; n <= 454; n++) begin
         step();
         check_run(n);
         if (n == 17)  check("first_frame_start", 32'(fs_a), 32'd1);
         if (n == 64)  check("no_de_before_65",   32'(de_a), 32'd0);
         if (n == 65)  check("first_de_x0",       32'(de_a), 32'd1);
         if (n == 48)  check("vsync_last",        32'(vs_a), 32'd1);
         if (n == 49)  check("vsync_end",         32'(vs_a), 32'd0);
         if (n == 68)  check("uf_set",            32'(uf_a), 32'd1);
         if (n == 151) check("uf_cleared",        32'(uf_a), 32'd0);
         if (n == 194) check("uf_set_wins",       32'(uf_a), 32'd1);
         if (n == 454) check("x_before_drop",     32'(x_a),  32'd5);
         fifo_empty = (n == 67) || (n == 193);
         clr_uf     = (n == 150) || (n == 193);
      end

      gen_en = 1'b0;
      step();
      check_idle("disable");
      step();
      check_idle("idle");
      check("idle_uf_held", 32'(uf_a), 32'd1);

      gen_en = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         step();
         check_run(n);
         if (n == 17) check("reen_frame_start", 32'(fs_a), 32'd1);
      end

      s_rst = 1'b1;
      step();
      check_idle("midrst");
      check("midrst_uf_zero", 32'(uf_a), 32'd0);
      s_rst = 1'b0;
      for (int n = 1; n <= 70; n++) begin
         step();
         check_run(n);
         if (n == 64) check("rst_no_de_64", 32'(de_a), 32'd0);
         if (n == 65) check("rst_first_de", 32'(de_a), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
